// File: rtl/sram_input_ctrl.sv
// rtl/sram_input_ctrl.sv - input SRAM initiator: stream LOAD and prefetching READ
// LOAD writes accepted beats to consecutive addresses; READ prefetches into a 3-entry FIFO.
module sram_input_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048,
  parameter int LEN_W  = 12
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              load_start,
  input  logic              read_start,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  popped;
  logic              inflight;
  logic [DATA_W-1:0] fifo [3];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [1:0]        fifo_count;

  logic              load_fire;
  logic              issue;
  logic              pop;
  logic [2:0]        occupancy;
  logic [ADDR_W-1:0] addr;

  always_comb begin
    occupancy = {1'b0, fifo_count} + {2'b00, inflight};
    addr      = ADDR_W'((LEN_W'(base_r) + cnt) % LEN_W'(DEPTH));
    load_fire = (state == LOAD) && in_valid;
    // A read already in flight reserves its FIFO slot, so the FIFO can never overflow.
    issue     = (state == READ) && (cnt < len_r) && (occupancy < 3'd3);
    pop       = out_valid && out_ready;
  end

  assign in_ready  = (state == LOAD);
  assign busy      = (state != IDLE);
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = out_valid ? fifo[rd_ptr] : '0;
  assign sram_cen  = !(load_fire || issue);
  assign sram_wen  = !load_fire;
  assign sram_a    = (load_fire || issue) ? addr : '0;
  assign sram_d    = load_fire ? in_data : '0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      base_r     <= '0;
      len_r      <= '0;
      cnt        <= '0;
      popped     <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 2'd0;
      done       <= 1'b0;
      for (int k = 0; k < 3; k++) fifo[k] <= '0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (inflight) begin
        fifo[wr_ptr] <= sram_q;
        wr_ptr       <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};

      case (state)
        IDLE: begin
          if (load_start || read_start) begin
            base_r <= base;
            len_r  <= len;
            cnt    <= '0;
            popped <= '0;
            if (len == '0) done <= 1'b1;
            else state <= load_start ? LOAD : READ;
          end
        end
        LOAD: begin
          if (load_fire) begin
            cnt <= cnt + LEN_W'(1);
            if (cnt == len_r - LEN_W'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) cnt <= cnt + LEN_W'(1);
          if (pop) begin
            popped <= popped + LEN_W'(1);
            if (popped == len_r - LEN_W'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_input_ctrl.sv
// tb/tb_sram_input_ctrl.sv - scoreboard bench for sram_input_ctrl
// Stimulus pushes expected writes, read addresses and read data; a negedge monitor pops and compares.
module tb_sram_input_ctrl;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2048;
  localparam int LEN_W  = 12;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              load_start = 1'b0;
  logic              read_start = 1'b0;
  logic [ADDR_W-1:0] base = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              done;
  logic              sram_cen;
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_d;
  logic [DATA_W-1:0] sram_q;

  sram_input_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RESET(RESET), .load_start(load_start), .read_start(read_start),
    .base(base), .len(len), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy),
    .done(done), .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a),
    .sram_d(sram_d), .sram_q(sram_q)
  );

  always #5 CLK = ~CLK;

  // SRAM macro behaviour: synchronous write, Q valid the cycle after a read.
  logic [DATA_W-1:0] sram_mem [DEPTH];
  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (!sram_wen) sram_mem[sram_a] <= sram_d;
      else sram_q <= sram_mem[sram_a];
    end
  end

  // Reference model state
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [ADDR_W-1:0] wr_a_q [$];
  logic [DATA_W-1:0] wr_d_q [$];
  logic [ADDR_W-1:0] rd_a_q [$];
  logic [DATA_W-1:0] data_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int issued = 0, popped = 0;
  int first_issue = -1, first_valid = -1, last_pop = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT event with empty scoreboard queue (t=%0t)", name, $time);
  endtask

  always @(negedge CLK) begin
    cyc++;
    if (!RESET) begin
      if (!sram_cen && !sram_wen) begin
        if (wr_a_q.size() == 0) unexpected("unexpected_write");
        else begin
          chk("write_addr", 32'(sram_a), 32'(wr_a_q.pop_front()));
          chk("write_data", sram_d, wr_d_q.pop_front());
        end
      end
      if (!sram_cen && sram_wen) begin
        if (rd_a_q.size() == 0) unexpected("unexpected_read");
        else begin
          chk("read_addr", 32'(sram_a), 32'(rd_a_q.pop_front()));
          issued++;
          if (first_issue < 0) first_issue = cyc;
          chk("outstanding_le_3", 32'(issued - popped <= 3), 32'd1);
        end
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) begin
        if (data_q.size() == 0) unexpected("unexpected_word");
        else chk("out_data", out_data, data_q.pop_front());
        popped++;
        last_pop = cyc;
      end
      if (done) done_cnt++;
    end
  end

  task automatic wait_done(input int budget);
    bit found = 0;
    for (int c = 0; c < budget && !found; c++) begin
      @(negedge CLK);
      if (done) found = 1;
    end
    chk("done_seen", 32'(found), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  // vmode: 0 in_valid always high, 1 random; fixed: data 0xA0+i; rs: also raise read_start
  task automatic do_load(input int b, input int n, input int vmode, input bit fixed, input bit rs);
    logic [DATA_W-1:0] ld [$];
    int idx = 0, guard = 0, d0;
    bit acc;
    d0 = done_cnt;
    for (int i = 0; i < n; i++) begin
      logic [DATA_W-1:0] v;
      v = fixed ? DATA_W'(32'hA0 + i) : DATA_W'($urandom);
      ld.push_back(v);
      wr_a_q.push_back(ADDR_W'((b + i) % DEPTH));
      wr_d_q.push_back(v);
      ref_mem[(b + i) % DEPTH] = v;
    end
    base = ADDR_W'(b);
    len = LEN_W'(n);
    load_start = 1;
    read_start = rs;
    @(posedge CLK);
    #1;
    load_start = 0;
    read_start = 0;
    while (idx < n && guard < 20000) begin
      in_valid = (vmode == 0) ? 1'b1 : ($urandom % 3 != 0);
      in_data = ld[idx];
      read_start = rs && (guard == 1);
      @(negedge CLK);
      acc = in_valid && in_ready;
      @(posedge CLK);
      #1;
      if (acc) idx++;
      guard++;
    end
    in_valid = 0;
    read_start = 0;
    chk("load_beats", 32'(idx), 32'(n));
    wait_done(20);
    chk("load_done_once", 32'(done_cnt - d0), 32'd1);
    chk("load_writes_drained", 32'(wr_a_q.size()), 32'd0);
  endtask

  // omode: 0 out_ready high, 1 pattern 1,0,0 repeating, 2 random
  task automatic do_read(input int b, input int n, input int omode);
    int k = 0, guard = 0, d0;
    d0 = done_cnt;
    issued = 0; popped = 0;
    first_issue = -1; first_valid = -1; last_pop = -1;
    for (int i = 0; i < n; i++) begin
      rd_a_q.push_back(ADDR_W'((b + i) % DEPTH));
      data_q.push_back(ref_mem[(b + i) % DEPTH]);
    end
    base = ADDR_W'(b);
    len = LEN_W'(n);
    read_start = 1;
    @(posedge CLK);
    #1;
    read_start = 0;
    while (k < n && guard < 20000) begin
      out_ready = (omode == 0) ? 1'b1 : (omode == 1) ? (guard % 3 == 0) : 1'($urandom % 2);
      @(negedge CLK);
      if (out_valid && out_ready) k++;
      @(posedge CLK);
      #1;
      guard++;
    end
    out_ready = 0;
    chk("read_words", 32'(k), 32'(n));
    wait_done(20);
    if (omode == 0) begin
      chk("read_latency", 32'(first_valid - first_issue), 32'd2);
      chk("read_no_bubbles", 32'(last_pop - first_valid), 32'(n - 1));
    end
    chk("read_done_once", 32'(done_cnt - d0), 32'd1);
    chk("read_queue_drained", 32'(data_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cen", 32'(sram_cen), 32'd1);
    chk("rst_wen", 32'(sram_wen), 32'd1);
    chk("rst_a", 32'(sram_a), 32'd0);
    chk("rst_d", sram_d, 32'd0);
    RESET = 0;
    @(posedge CLK);
    #1;

    do_load(0, 4, 0, 1, 0);
    do_load(4, DEPTH - 4, 0, 0, 0);
    do_read(0, 4, 0);
    do_load(2046, 4, 1, 0, 0);
    do_read(2046, 4, 0);
    do_read(100, 8, 1);

    // load_start and read_start together, then read_start during LOAD: only LOAD runs
    do_load(300, 3, 0, 0, 1);
    chk("idle_after_both", 32'(busy), 32'd0);

    // zero-length starts
    for (int m = 0; m < 2; m++) begin
      base = 11'd5;
      len = '0;
      load_start = (m == 0);
      read_start = (m == 1);
      @(posedge CLK);
      #1;
      load_start = 0;
      read_start = 0;
      chk("len0_done", 32'(done), 32'd1);
      chk("len0_cen", 32'(sram_cen), 32'd1);
      chk("len0_busy", 32'(busy), 32'd0);
      @(posedge CLK);
      #1;
      chk("len0_done_cleared", 32'(done), 32'd0);
    end

    // reset in the middle of a stalled READ
    issued = 0; popped = 0;
    for (int i = 0; i < 8; i++) begin
      rd_a_q.push_back(ADDR_W'(i));
      data_q.push_back(ref_mem[i]);
    end
    base = '0;
    len = LEN_W'(8);
    out_ready = 0;
    read_start = 1;
    @(posedge CLK);
    #1;
    read_start = 0;
    repeat (5) @(posedge CLK);
    #1;
    chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
    RESET = 1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_cen", 32'(sram_cen), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    rd_a_q.delete();
    data_q.delete();
    @(posedge CLK);
    #1;
    RESET = 0;
    @(posedge CLK);
    #1;
    do_read(0, 4, 2);

    // randomized traffic
    for (int r = 0; r < 8; r++) begin
      do_load(int'($urandom % DEPTH), 1 + int'($urandom % 16), 1, 0, 0);
      do_read(int'($urandom % DEPTH), 1 + int'($urandom % 20), int'($urandom % 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
